// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and helpers for the block memory model.
package mem_pkg;

  localparam int ADDR_W     = 10;
  localparam int BLOCK_W    = 128;
  localparam int NUM_BLOCKS = 64;
  localparam int OFFSET_W   = 4;
  localparam int IDX_W      = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] mem_t;

  function automatic logic [IDX_W-1:0] block_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

  // Power-up image: each byte holds the low 8 bits of its own byte address,
  // with byte offset 0 in the most significant lane.
  function automatic mem_t init_mem();
    mem_t m;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      for (int k = 0; k < 16; k++) begin
        m[b][BLOCK_W-1-8*k -: 8] = 8'(b * 16 + k);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_block_array.sv
// 64 x 128-bit block storage, one synchronous write port and one combinational read port.
// Contents come up with the address pattern and are never cleared by reset.
module mem_block_array
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BLOCK_W-1:0] rd_data
);

  mem_t mem = init_mem();

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/block_memory_sync.sv
// Fixed-latency block memory: one request in flight, response LATENCY cycles after acceptance.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module block_memory_sync #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [BLOCK_W-1:0] resp_rdata
);

  mem_pkg::state_t state, state_nxt;

  logic [3:0]                 cnt;
  logic                       lat_write;
  logic [mem_pkg::IDX_W-1:0]  lat_idx;
  logic [BLOCK_W-1:0]         lat_wdata;
  logic                       wr_en;
  logic [BLOCK_W-1:0]         rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= mem_pkg::IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      mem_pkg::IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = mem_pkg::BUSY;
      end
      mem_pkg::BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = mem_pkg::RESP;
          wr_en     = lat_write;
        end
      end
      mem_pkg::RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = mem_pkg::IDLE;
      end
      default: state_nxt = mem_pkg::IDLE;
    endcase
  end

  // Write data bypasses the array so the response reflects the post-commit block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      if (state == mem_pkg::IDLE && req_valid) begin
        lat_write <= req_write;
        lat_idx   <= mem_pkg::block_idx(req_addr);
        lat_wdata <= req_wdata;
        cnt       <= 4'(LATENCY - 1);
      end
      if (state == mem_pkg::BUSY) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          resp_rdata <= lat_write ? lat_wdata : rd_data;
        end
      end
    end
  end

  mem_block_array u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (lat_idx),
    .wr_data (lat_wdata),
    .rd_idx  (lat_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_block_memory_sync.sv
// Directed and randomized checks of block_memory_sync against a byte-addressed reference memory.
module tb_block_memory_sync;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [9:0]   req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   model [1024];
  logic [127:0] last_rdata;

  block_memory_sync #(.ADDR_W(10), .BLOCK_W(128), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_rd(input logic [9:0] a);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = model[{a[9:4], 4'(k)}];
    return r;
  endfunction

  task automatic model_wr(input logic [9:0] a, input logic [127:0] d);
    for (int k = 0; k < 16; k++) model[{a[9:4], 4'(k)}] = d[127-8*k -: 8];
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  // One complete transaction; bp = cycles of resp_ready low after resp_valid.
  task automatic transact(input logic wr, input logic [9:0] a, input logic [127:0] d, input int bp);
    logic [127:0] exp;
    int lat;
    if (wr) model_wr(a, d);
    exp = model_rd(a);
    @(negedge clk);
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    resp_ready = (bp == 0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 10'($urandom); req_wdata = '0;
    chk("req_ready_busy", 128'(req_ready), 128'(0));
    wait_resp(lat);
    chk("latency", 128'(lat), 128'(LAT));
    chk("rdata", resp_rdata, exp);
    last_rdata = resp_rdata;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h000;
      @(posedge clk); @(negedge clk);
      chk("bp_valid", 128'(resp_valid), 128'(1));
      chk("bp_rdata", resp_rdata, exp);
      chk("bp_req_ready", 128'(req_ready), 128'(0));
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("consumed_valid", 128'(resp_valid), 128'(0));
    chk("consumed_ready", 128'(req_ready), 128'(1));
  endtask

  initial begin
    int lat;
    logic [127:0] d;
    for (int i = 0; i < 1024; i++) model[i] = 8'(i);
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_rdata", resp_rdata, 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 128'(req_ready), 128'(1));

    // Read 0x010
    transact(1'b0, 10'h010, '0, 0);
    chk("read_010_const", last_rdata, 128'h101112131415161718191A1B1C1D1E1F);

    // Write then read back through a different offset
    transact(1'b1, 10'h020, 128'hDEADBEEF_00112233_44556677_8899AABB, 0);
    chk("write_echo", last_rdata, 128'hDEADBEEF_00112233_44556677_8899AABB);
    transact(1'b0, 10'h02C, '0, 0);
    chk("readback_02C", last_rdata, 128'hDEADBEEF_00112233_44556677_8899AABB);

    // Backpressure with a concurrent read request
    transact(1'b0, 10'h050, '0, 3);

    // Reset during an uncommitted write: storage unchanged
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h030;
    req_wdata = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D; resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_req_ready", 128'(req_ready), 128'(1));
    chk("midrst_resp_valid", 128'(resp_valid), 128'(0));
    chk("midrst_resp_rdata", resp_rdata, 128'(0));
    @(negedge clk); rst_n = 1'b1;
    transact(1'b0, 10'h030, '0, 0);
    chk("dropped_write_030", last_rdata, 128'h303132333435363738393A3B3C3D3E3F);

    // Reset while a committed write is held in RESP: write persists
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h0A7; req_wdata = d; resp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    wait_resp(lat);
    chk("resp_latency_pre_rst", 128'(lat), 128'(LAT));
    rst_n = 1'b0; #1;
    chk("resp_rst_valid", 128'(resp_valid), 128'(0));
    chk("resp_rst_rdata", resp_rdata, 128'(0));
    @(negedge clk); rst_n = 1'b1; resp_ready = 1'b1;
    model_wr(10'h0A7, d);
    transact(1'b0, 10'h0A0, '0, 0);
    chk("committed_write_kept", last_rdata, d);

    // Offset bits ignored
    transact(1'b0, 10'h3FF, '0, 0);
    chk("read_3FF_const", last_rdata, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      transact(1'($urandom_range(0, 1)), 10'($urandom), {$urandom, $urandom, $urandom, $urandom},
               int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
